mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Parametrised successor to the combinational byte-enable decoder in the multicycle CPU. It turns a load/store opcode and an effective address into a handshaked data-memory transaction.
- Generates byte enables, lane-replicated store data and sign/zero-extended load data.
- Detects misaligned and illegal accesses.
- Supports 32-bit and 64-bit data paths. The 64-bit path adds LWU/LD/SD.
- Sits between the MEM-state control FSM and the DM.

Parameters:
DATA_W, 32, data path width; legal values 32 or 64.
ADDR_W, 32, effective address width.
DM_ADDR_W, 12, DM address width. The DM address is the truncated effective address.
NB, DATA_W/8, derived lane count. Not overridable.
LB, log2(NB), derived lane-select bit count. Not overridable.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request from control FSM; sampled only in IDLE
op  in  6  MIPS primary opcode
addr  in  ADDR_W  effective address
wdata  in  DATA_W  store source (rt), right-aligned
busy  out  1  high in REQ
done  out  1  one-cycle completion pulse
rdata  out  DATA_W  extended load result; held until the next start
misalign  out  1  sticky-per-access; valid with done
illegal_op  out  1  valid with done
dm_addr  out  DM_ADDR_W  DM address, lane bits forced to 0
dm_be  out  NB  byte enables
dm_wdata  out  DATA_W  lane-positioned store data
dm_we  out  1  write strobe
dm_re  out  1  read strobe
dm_ack  in  1  DM completion; may arrive in the same cycle as the strobe
dm_rdata  in  DATA_W  DM read data, valid when dm_ack=1

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; busy, done, misalign, illegal_op, dm_we, dm_re = 0; dm_be=0; dm_addr=0; dm_wdata=0; rdata=0.
- Reset mid-access: the strobes drop immediately (asynchronously). No done pulse is produced.
- Opcodes:
  - Loads: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011.
  - Stores: SB 101000, SH 101001, SW 101011.
  - DATA_W=64 only: LWU 100111, LD 110111, SD 111111.
  - Any other opcode, or a 64-bit opcode when DATA_W=32, is illegal.
- Signedness: LBU, LHU and LWU zero-extend. All other loads sign-extend.
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1:
  - Capture op, addr and wdata into registers.
  - Illegal op: go to DONE with illegal_op=1 and no DM access.
  - Misaligned: go to DONE with misalign=1 and no DM access.
    - Half-word: addr[0]≠0.
    - Word: addr[1:0]≠0.
    - Double-word: addr[2:0]≠0.
  - Otherwise: go to REQ.
- REQ:
  - dm_re (load) or dm_we (store) is held high.
  - dm_addr, dm_be and dm_wdata are registered and stable throughout REQ.
  - dm_ack=1 causes a transition to DONE. A load captures rdata on that edge.
  - There is no timeout. REQ waits indefinitely.
- DONE: done=1 for exactly one cycle, then return to IDLE. misalign and illegal_op clear on the next start.
- start outside IDLE is ignored; it is not queued.
- Latency: start at cycle N, dm strobe at N+1. With ack at N+1, done is at N+2. Error accesses give done at N+1.
- Byte enables, with lane k = addr[LB-1:0]:
  - Byte: bit k set.
  - Half: bits k and k+1 set.
  - Word: 4'b1111 shifted by k (k = 0 or 4 when 64-bit).
  - Double: all ones.
- Store data: wdata is replicated across lanes.
  - Byte: wdata[7:0] in every byte.
  - Half: wdata[15:0] in every half.
  - Word: wdata[31:0] in every word.
- Load data: the addressed field is extracted from dm_rdata at lane k and right-aligned, then extended to DATA_W.

Decomposition:
- Shared package mem_pkg:
  - Opcode constants (OP_LB … OP_SD).
  - Access-size enum: BYTE, HALF, WORD, DWORD.
  - FSM state enum.
- Sub-module mem_lane_align: purely combinational.
  - Inputs: size, signedness, lane offset, store data, raw read data.
  - Outputs: BE, replicated store data, extended load data.
  - Reused by the future cache path.
- The top level holds the decode, the FSM and the registers.

Test Plan:
- DATA_W=32. LB at addr=0x0000_0003, dm_rdata=0x80AB_CDEF, ack at the strobe cycle -> dm_be=4'b1000, dm_addr=0x000, rdata=0xFFFF_FF80, done 2 cycles after start.
- SH at addr=0x0000_0106, wdata=0x1234_BEEF, ack delayed 3 cycles -> dm_we held for 4 cycles, dm_be=4'b1100, dm_wdata=0xBEEF_BEEF, dm_addr=0x104, busy=1 throughout.
- LW at addr=0x0000_0002 -> misalign=1, done at start+1, dm_re/dm_we never asserted.
- op=6'b000000 (R-type) -> illegal_op=1, done at start+1. DATA_W=32 with LD -> illegal_op=1.
- DATA_W=64. LWU at addr=0x...4, dm_rdata=0x8765_4321_0000_0000 -> dm_be=8'hF0, rdata=0x0000_0000_8765_4321. SD at addr=0x8 -> dm_be=8'hFF.
- rst_n pulled low during REQ -> dm_re=0 immediately, state IDLE, no done. A second start during REQ is ignored, and the first access completes with the original op.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: opcodes, access sizes,
// FSM states and the opcode decoder.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LWU = 6'b100111;
    localparam logic [5:0] OP_LD  = 6'b110111;
    localparam logic [5:0] OP_SD  = 6'b111111;

    typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} size_e;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

    typedef struct packed {
        logic  legal;
        logic  is_load;
        logic  is_store;
        logic  sign_ext;
        size_e size;
    } op_dec_t;

    // The 64-bit-only opcodes decode as illegal unless the data path is wide.
    function automatic op_dec_t decode_op(input logic [5:0] op, input logic wide);
        op_dec_t d;
        d.legal    = 1'b1;
        d.is_load  = 1'b1;
        d.is_store = 1'b0;
        d.sign_ext = 1'b1;
        d.size     = BYTE;
        case (op)
            OP_LB:  d.size = BYTE;
            OP_LBU: begin d.size = BYTE; d.sign_ext = 1'b0; end
            OP_LH:  d.size = HALF;
            OP_LHU: begin d.size = HALF; d.sign_ext = 1'b0; end
            OP_LW:  d.size = WORD;
            OP_LWU: begin d.size = WORD; d.sign_ext = 1'b0; d.legal = wide; end
            OP_LD:  begin d.size = DWORD; d.legal = wide; end
            OP_SB:  begin d.size = BYTE;  d.is_load = 1'b0; d.is_store = 1'b1; end
            OP_SH:  begin d.size = HALF;  d.is_load = 1'b0; d.is_store = 1'b1; end
            OP_SW:  begin d.size = WORD;  d.is_load = 1'b0; d.is_store = 1'b1; end
            OP_SD:  begin d.size = DWORD; d.is_load = 1'b0; d.is_store = 1'b1; d.legal = wide; end
            default: d.legal = 1'b0;
        endcase
        if (!d.legal) begin
            d.is_load  = 1'b0;
            d.is_store = 1'b0;
        end
        return d;
    endfunction

    function automatic logic misaligned(input size_e size, input logic [2:0] low);
        case (size)
            HALF:    return low[0];
            WORD:    return low[1:0] != 2'b00;
            DWORD:   return low != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the DM (slave).
interface mem_access_unit_if #(
    parameter int DATA_W    = 32,
    parameter int DM_ADDR_W = 12
);
    logic [DM_ADDR_W-1:0] dm_addr;
    logic [DATA_W/8-1:0]  dm_be;
    logic [DATA_W-1:0]    dm_wdata;
    logic                 dm_we;
    logic                 dm_re;
    logic                 dm_ack;
    logic [DATA_W-1:0]    dm_rdata;

    modport master (
        output dm_addr, dm_be, dm_wdata, dm_we, dm_re,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_addr, dm_be, dm_wdata, dm_we, dm_re,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LB     = $clog2(NB)
) (
    input  size_e             size,
    input  logic              sign_ext,
    input  logic [LB-1:0]     lane,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] rd_raw,
    output logic [NB-1:0]     be,
    output logic [DATA_W-1:0] st_rep,
    output logic [DATA_W-1:0] ld_ext
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              msb;

    always_comb begin
        be = '1;
        case (size)
            BYTE:    be = NB'(1)  << lane;
            HALF:    be = NB'(3)  << lane;
            WORD:    be = NB'(15) << lane;
            default: be = '1;
        endcase
    end

    // Each byte lane takes the source byte at the same offset within its field.
    always_comb begin
        st_rep = '0;
        for (int i = 0; i < NB; i++) begin
            case (size)
                BYTE:    st_rep[8*i +: 8] = st_data[7:0];
                HALF:    st_rep[8*i +: 8] = st_data[8*(i%2) +: 8];
                WORD:    st_rep[8*i +: 8] = st_data[8*(i%4) +: 8];
                default: st_rep[8*i +: 8] = st_data[8*i +: 8];
            endcase
        end
    end

    always_comb begin
        shifted = rd_raw >> {lane, 3'b000};
        mask    = '1;
        msb     = 1'b0;
        case (size)
            BYTE:    begin mask = DATA_W'(8'hFF);          msb = shifted[7];  end
            HALF:    begin mask = DATA_W'(16'hFFFF);       msb = shifted[15]; end
            WORD:    begin mask = DATA_W'(32'hFFFF_FFFF);  msb = shifted[31]; end
            default: begin mask = '1;                      msb = 1'b0;        end
        endcase
        ld_ext = (shifted & mask) | ((sign_ext && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit: decodes the opcode, checks alignment and runs one
// handshaked DM transaction per start request.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DM_ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [5:0]         op,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  rdata,
    output logic               misalign,
    output logic               illegal_op,
    mem_access_unit_if.master  dm
);

    localparam int   NB   = DATA_W / 8;
    localparam int   LB   = $clog2(NB);
    localparam logic WIDE = (DATA_W == 64);

    state_e                state_q, state_d;
    logic [5:0]            op_q, op_d;
    logic [LB-1:0]         lane_q, lane_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  misalign_q, misalign_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DM_ADDR_W-1:0]  dm_addr_q, dm_addr_d;
    logic [NB-1:0]         dm_be_q, dm_be_d;
    logic [DATA_W-1:0]     dm_wdata_q, dm_wdata_d;
    logic                  dm_we_q, dm_we_d;
    logic                  dm_re_q, dm_re_d;

    logic                  in_idle;
    logic [5:0]            cur_op;
    logic [LB-1:0]         cur_lane;
    op_dec_t               dec;
    logic                  is_mis;
    logic [NB-1:0]         be;
    logic [DATA_W-1:0]     st_rep;
    logic [DATA_W-1:0]     ld_ext;
    logic                  unused_addr;

    // In IDLE the aligner works on the live request; in REQ on the captured one.
    assign in_idle     = (state_q == IDLE);
    assign cur_op      = in_idle ? op : op_q;
    assign cur_lane    = in_idle ? addr[LB-1:0] : lane_q;
    assign dec         = decode_op(cur_op, WIDE);
    assign is_mis      = misaligned(dec.size, addr[2:0]);
    assign unused_addr = ^addr;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size     (dec.size),
        .sign_ext (dec.sign_ext),
        .lane     (cur_lane),
        .st_data  (wdata),
        .rd_raw   (dm.dm_rdata),
        .be       (be),
        .st_rep   (st_rep),
        .ld_ext   (ld_ext)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        lane_d     = lane_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        misalign_d = misalign_q;
        illegal_d  = illegal_q;
        rdata_d    = rdata_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        dm_we_d    = dm_we_q;
        dm_re_d    = dm_re_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    lane_d     = addr[LB-1:0];
                    misalign_d = 1'b0;
                    illegal_d  = 1'b0;
                    if (!dec.legal) begin
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end else if (is_mis) begin
                        misalign_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else begin
                        busy_d     = 1'b1;
                        dm_addr_d  = {addr[DM_ADDR_W-1:LB], {LB{1'b0}}};
                        dm_be_d    = be;
                        dm_wdata_d = st_rep;
                        dm_we_d    = dec.is_store;
                        dm_re_d    = dec.is_load;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (dm.dm_ack) begin
                    if (dm_re_q) begin
                        rdata_d = ld_ext;
                    end
                    busy_d  = 1'b0;
                    dm_we_d = 1'b0;
                    dm_re_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            lane_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            rdata_q    <= '0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
            dm_we_q    <= 1'b0;
            dm_re_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            lane_q     <= lane_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
            rdata_q    <= rdata_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            dm_we_q    <= dm_we_d;
            dm_re_q    <= dm_re_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign misalign    = misalign_q;
    assign illegal_op  = illegal_q;
    assign dm.dm_addr  = dm_addr_q;
    assign dm.dm_be    = dm_be_q;
    assign dm.dm_wdata = dm_wdata_q;
    assign dm.dm_we    = dm_we_q;
    assign dm.dm_re    = dm_re_q;

endmodule
